// File: rtl/bus_drive_ctrl.sv
// bus_drive_ctrl: upstream control for the 8-bit tristate bus buffer.
// Bytes enter through a valid/ready FIFO. The block requests the shared bus
// with BUS_REQ/BUS_GNT and drives E/I, holding each byte for HOLD_CYCLES.
// It then releases the bus through TURN_CYCLES dead cycles.
//
// Optional build macro BUS_DRIVE_ABORT_CNT_EN adds ABORT_CNT. ABORT_CNT is a
// saturating count of bytes aborted by grant loss.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | bus released, waiting for the FIFO to hold a byte
// REQ    | BUS_REQ high, waiting for BUS_GNT
// DRIVE  | E high, head byte on I, hold timer running
// TURN   | E and BUS_REQ low for TURN_CYCLES before going back to IDLE
module bus_drive_ctrl #(
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 2,
  parameter int TURN_CYCLES = 1,
  parameter int MAX_BURST   = 4
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       IN_VALID,
  input  logic [7:0] IN_DATA,
  output logic       IN_READY,
  input  logic       BUS_GNT,
  output logic       BUS_REQ,
  output logic       E,
  output logic [7:0] I,
  output logic       DONE
`ifdef BUS_DRIVE_ABORT_CNT_EN
  ,
  output logic [7:0] ABORT_CNT
`endif
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int TW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_DRIVE = 2'd2;
  localparam logic [1:0] S_TURN  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [TW-1:0] turn_q, turn_d;
  logic [BW-1:0] burst_q, burst_d;
  logic [7:0]    i_q, i_d;
  logic          e_q, e_d;
  logic          req_q, req_d;
  logic          done_q, done_d;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;

  logic          full, empty, push, pop, more;
  logic [7:0]    head, next_head;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign push      = IN_VALID && !full;
  assign pop       = (state_q == S_DRIVE) && (hold_q == '0) && !empty;
  // "Still non-empty after the pop" counts only bytes already stored.
  // A byte pushed on the same edge cannot be loaded onto I yet.
  assign more      = (count_q > CW'(1));
  assign head      = mem[rd_ptr_q];
  assign next_head = mem[rd_ptr_q + PW'(1)];

  assign IN_READY  = !full;
  assign BUS_REQ   = req_q;
  assign E         = e_q;
  assign I         = i_q;
  assign DONE      = done_q;

  // FIFO storage; no reset needed, occupancy is tracked by the pointers
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr_q] <= IN_DATA;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  // Next-state, timer and data-load decisions
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    turn_d  = turn_q;
    burst_d = burst_q;
    i_d     = i_q;
    case (state_q)
      S_IDLE: begin
        if (!empty) state_d = S_REQ;
      end
      S_REQ: begin
        if (BUS_GNT) begin
          state_d = S_DRIVE;
          hold_d  = HW'(HOLD_CYCLES - 1);
          burst_d = BW'(MAX_BURST - 1);
          i_d     = head;
        end
      end
      S_DRIVE: begin
        if (hold_q == '0) begin
          if (more && BUS_GNT && (burst_q != '0)) begin
            hold_d  = HW'(HOLD_CYCLES - 1);
            burst_d = burst_q - BW'(1);
            i_d     = next_head;
          end else begin
            state_d = S_TURN;
            turn_d  = TW'(TURN_CYCLES - 1);
          end
        end else if (!BUS_GNT) begin
          // Grant lost mid-byte: the byte stays in the FIFO for a retry
          state_d = S_TURN;
          turn_d  = TW'(TURN_CYCLES - 1);
        end else begin
          hold_d = hold_q - HW'(1);
        end
      end
      S_TURN: begin
        if (turn_q == '0) state_d = S_IDLE;
        else              turn_d  = turn_q - TW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it
  always_comb begin
    e_d    = (state_d == S_DRIVE);
    req_d  = (state_d == S_REQ) || (state_d == S_DRIVE);
    done_d = (state_d == S_DRIVE) && (hold_d == '0);
  end

  // State, timers and registered bus outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      hold_q  <= '0;
      turn_q  <= '0;
      burst_q <= '0;
      i_q     <= 8'h00;
      e_q     <= 1'b0;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      turn_q  <= turn_d;
      burst_q <= burst_d;
      i_q     <= i_d;
      e_q     <= e_d;
      req_q   <= req_d;
      done_q  <= done_d;
    end
  end

`ifdef BUS_DRIVE_ABORT_CNT_EN
  logic       abort;
  logic [7:0] abort_cnt_q;

  assign abort     = (state_q == S_DRIVE) && (hold_q != '0) && !BUS_GNT;
  assign ABORT_CNT = abort_cnt_q;

  // Saturating count of grant-loss aborts
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                             abort_cnt_q <= 8'h00;
    else if (abort && abort_cnt_q != 8'hFF) abort_cnt_q <= abort_cnt_q + 8'h01;
  end
`else
  // Grant-loss aborts are not counted in this build.
`endif

endmodule

// File: tb/tb_bus_drive_ctrl.sv
// Self-checking bench for bus_drive_ctrl: directed timeline scenarios plus a
// randomized run checked against a transaction-level queue model.
module tb_bus_drive_ctrl;

  localparam int DEPTH = 4;
  localparam int HOLD  = 2;
  localparam int TURN  = 1;
  localparam int MAXB  = 4;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       IN_VALID = 1'b0;
  logic [7:0] IN_DATA = 8'h00;
  logic       BUS_GNT = 1'b0;
  logic       IN_READY, BUS_REQ, E, DONE;
  logic [7:0] I;
`ifdef BUS_DRIVE_ABORT_CNT_EN
  logic [7:0] ABORT_CNT;
`endif

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  bus_drive_ctrl #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD), .TURN_CYCLES(TURN), .MAX_BURST(MAXB)) dut (
    .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_DATA(IN_DATA), .IN_READY(IN_READY),
    .BUS_GNT(BUS_GNT), .BUS_REQ(BUS_REQ), .E(E), .I(I), .DONE(DONE)
`ifdef BUS_DRIVE_ABORT_CNT_EN
    , .ABORT_CNT(ABORT_CNT)
`endif
  );

  task automatic apply_reset();
    IN_VALID = 1'b0;
    IN_DATA  = 8'h00;
    RST_N    = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  // Present one byte and hold it until the handshake completes
  task automatic send(input logic [7:0] b);
    bit ok;
    ok = 0;
    IN_VALID = 1'b1;
    IN_DATA  = b;
    for (int t = 0; t < 60; t++) begin
      @(negedge CLK);
      if (IN_READY === 1'b1) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_timeout: byte %0h IN_READY=%0b expected 1", b, IN_READY);
    end
    @(posedge CLK);
    #1;
    IN_VALID = 1'b0;
  endtask

  task automatic test_reset();
    BUS_GNT = 1'b0;
    RST_N   = 1'b0;
    @(posedge CLK);
    #1;
    checks++; if (BUS_REQ !== 1'b0) begin errors++; $display("FAIL rst_bus_req: got %0b expected 0", BUS_REQ); end
    checks++; if (E !== 1'b0)       begin errors++; $display("FAIL rst_e: got %0b expected 0", E); end
    checks++; if (I !== 8'h00)      begin errors++; $display("FAIL rst_i: got %0h expected 00", I); end
    checks++; if (DONE !== 1'b0)    begin errors++; $display("FAIL rst_done: got %0b expected 0", DONE); end
    checks++; if (IN_READY !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %0b expected 1", IN_READY); end
`ifdef BUS_DRIVE_ABORT_CNT_EN
    checks++; if (ABORT_CNT !== 8'h00) begin errors++; $display("FAIL rst_abort_cnt: got %0h expected 00", ABORT_CNT); end
`endif
    apply_reset();
    @(negedge CLK);
    checks++; if (BUS_REQ !== 1'b0 || E !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset: req=%0b e=%0b expected 0 0", BUS_REQ, E);
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic test_single_byte();
    bit exp_req [0:6];
    bit exp_e   [0:6];
    bit exp_done[0:6];
    exp_req  = '{0, 0, 1, 1, 1, 0, 0};
    exp_e    = '{0, 0, 0, 1, 1, 0, 0};
    exp_done = '{0, 0, 0, 0, 1, 0, 0};
    BUS_GNT = 1'b1;
    apply_reset();
    for (int k = 0; k < 7; k++) begin
      if (k == 0) begin IN_VALID = 1'b1; IN_DATA = 8'hA5; end
      else IN_VALID = 1'b0;
      @(negedge CLK);
      checks++; if (BUS_REQ !== exp_req[k]) begin errors++; $display("FAIL single_req c%0d: got %0b expected %0b", k, BUS_REQ, exp_req[k]); end
      checks++; if (E !== exp_e[k]) begin errors++; $display("FAIL single_e c%0d: got %0b expected %0b", k, E, exp_e[k]); end
      checks++; if (DONE !== exp_done[k]) begin errors++; $display("FAIL single_done c%0d: got %0b expected %0b", k, DONE, exp_done[k]); end
      if (k >= 3 && k <= 5) begin
        checks++; if (I !== 8'hA5) begin errors++; $display("FAIL single_i c%0d: got %0h expected a5", k, I); end
      end
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic test_burst_limit();
    int dones;
    dones = 0;
    BUS_GNT = 1'b1;
    apply_reset();
    fork
      begin
        for (int b = 1; b <= 6; b++) send(8'(b));
      end
      begin
        for (int k = 0; k < 20; k++) begin
          bit xe, xr, xd;
          logic [7:0] xi;
          xe = (k >= 3 && k <= 10) || (k >= 14 && k <= 17);
          xr = (k >= 2 && k <= 10) || (k >= 13 && k <= 17);
          xi = (k <= 10) ? 8'((k - 3) / 2 + 1) : 8'((k - 14) / 2 + 5);
          xd = xe && (((k <= 10) ? (k - 3) : (k - 14)) % 2 == 1);
          @(negedge CLK);
          checks++; if (E !== xe) begin errors++; $display("FAIL burst_e c%0d: got %0b expected %0b", k, E, xe); end
          checks++; if (BUS_REQ !== xr) begin errors++; $display("FAIL burst_req c%0d: got %0b expected %0b", k, BUS_REQ, xr); end
          checks++; if (DONE !== xd) begin errors++; $display("FAIL burst_done c%0d: got %0b expected %0b", k, DONE, xd); end
          if (xe) begin
            checks++; if (I !== xi) begin errors++; $display("FAIL burst_i c%0d: got %0h expected %0h", k, I, xi); end
          end
          if (k == 4) begin
            checks++; if (IN_READY !== 1'b0) begin errors++; $display("FAIL burst_full c4: got %0b expected 0", IN_READY); end
          end
          if (k == 5) begin
            checks++; if (IN_READY !== 1'b1) begin errors++; $display("FAIL burst_ready c5: got %0b expected 1", IN_READY); end
          end
          if (DONE === 1'b1) dones++;
        end
      end
    join
    checks++; if (dones != 6) begin errors++; $display("FAIL burst_done_count: got %0d expected 6", dones); end
    @(posedge CLK);
    #1;
  endtask

  task automatic test_grant_loss();
    BUS_GNT = 1'b1;
    apply_reset();
    for (int k = 0; k < 14; k++) begin
      bit xe, xr, xd;
      xe = (k == 3) || (k == 8) || (k == 9);
      xr = (k == 2) || (k == 3) || (k >= 6 && k <= 9);
      xd = (k == 9);
      IN_VALID = (k == 0);
      IN_DATA  = 8'h3C;
      if (k == 3) BUS_GNT = 1'b0;
      if (k == 7) BUS_GNT = 1'b1;
      @(negedge CLK);
      checks++; if (E !== xe) begin errors++; $display("FAIL gloss_e c%0d: got %0b expected %0b", k, E, xe); end
      checks++; if (BUS_REQ !== xr) begin errors++; $display("FAIL gloss_req c%0d: got %0b expected %0b", k, BUS_REQ, xr); end
      checks++; if (DONE !== xd) begin errors++; $display("FAIL gloss_done c%0d: got %0b expected %0b", k, DONE, xd); end
      if (xe) begin
        checks++; if (I !== 8'h3C) begin errors++; $display("FAIL gloss_i c%0d: got %0h expected 3c", k, I); end
      end
      if (k == 4) begin
        checks++; if (IN_READY !== 1'b1) begin errors++; $display("FAIL gloss_ready c4: got %0b expected 1", IN_READY); end
      end
`ifdef BUS_DRIVE_ABORT_CNT_EN
      if (k == 10) begin
        checks++; if (ABORT_CNT !== 8'h01) begin errors++; $display("FAIL gloss_abort_cnt: got %0h expected 01", ABORT_CNT); end
      end
`endif
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic test_full_fifo();
    logic [7:0] got[$];
    logic [7:0] want[$];
    int acc_k;
    want = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h55};
    acc_k = -1;
    BUS_GNT = 1'b0;
    apply_reset();
    for (int k = 0; k < 31; k++) begin
      if (k < 4) begin IN_VALID = 1'b1; IN_DATA = 8'(8'h10 + k); end
      else begin IN_VALID = (acc_k < 0); IN_DATA = 8'h55; end
      if (k == 8) BUS_GNT = 1'b1;
      @(negedge CLK);
      if (k == 4 || k == 7 || k == 10) begin
        checks++; if (IN_READY !== 1'b0) begin errors++; $display("FAIL full_ready c%0d: got %0b expected 0", k, IN_READY); end
      end
      if (k == 11) begin
        checks++; if (IN_READY !== 1'b1) begin errors++; $display("FAIL full_ready_after_pop c11: got %0b expected 1", IN_READY); end
      end
      if (k >= 4 && IN_VALID && IN_READY === 1'b1 && acc_k < 0) acc_k = k;
      if (DONE === 1'b1) got.push_back(I);
      @(posedge CLK);
      #1;
    end
    IN_VALID = 1'b0;
    checks++; if (acc_k != 11) begin errors++; $display("FAIL full_fifth_accept: cycle %0d expected 11", acc_k); end
    checks++; if (got != want) begin errors++; $display("FAIL full_order: got %0d bytes expected 5 in order 10 11 12 13 55", got.size()); end
  endtask

  task automatic test_reset_mid_drive();
    BUS_GNT = 1'b1;
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      IN_VALID = (k < 3);
      IN_DATA  = 8'(8'hC0 + k);
      @(negedge CLK);
      if (k == 3) begin
        checks++; if (E !== 1'b1) begin errors++; $display("FAIL rmid_pre_e: got %0b expected 1", E); end
      end
      if (k < 3) begin @(posedge CLK); #1; end
    end
    #2;
    RST_N = 1'b0;
    #1;
    checks++; if (E !== 1'b0)       begin errors++; $display("FAIL rmid_async_e: got %0b expected 0", E); end
    checks++; if (BUS_REQ !== 1'b0) begin errors++; $display("FAIL rmid_async_req: got %0b expected 0", BUS_REQ); end
    checks++; if (DONE !== 1'b0)    begin errors++; $display("FAIL rmid_async_done: got %0b expected 0", DONE); end
    @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      checks++; if (IN_READY !== 1'b1 || E !== 1'b0 || BUS_REQ !== 1'b0) begin
        errors++; $display("FAIL rmid_after c%0d: ready=%0b e=%0b req=%0b expected 1 0 0", k, IN_READY, E, BUS_REQ);
      end
    end
    @(posedge CLK);
    #1;
  endtask

  // Randomized traffic checked against a byte queue and the drive rules
  task automatic test_random();
    logic [7:0] q[$];
    int run, burst, since_fall, completed, aborts;
    bit prev_e, prev_mid, prev_gnt, rdy, xd;
    run = 0; burst = 0; since_fall = TURN; completed = 0; aborts = 0;
    prev_e = 0; prev_mid = 0; prev_gnt = 0;
    BUS_GNT = 1'b0;
    apply_reset();
    for (int c = 0; c < 900; c++) begin
      if (c < 850) begin
        IN_VALID = ($urandom % 2) == 1;
        IN_DATA  = 8'($urandom);
        BUS_GNT  = ($urandom % 10) < 7;
      end else begin
        IN_VALID = 1'b0;
        BUS_GNT  = 1'b1;
      end
      @(negedge CLK);
      rdy = (q.size() < DEPTH);
      xd  = 0;
      checks++; if (IN_READY !== rdy) begin errors++; $display("FAIL rnd_ready c%0d: got %0b expected %0b", c, IN_READY, rdy); end
      if (prev_mid) begin
        checks++; if (E !== prev_gnt) begin errors++; $display("FAIL rnd_grant_follow c%0d: e=%0b expected %0b", c, E, prev_gnt); end
      end
      if (E === 1'b1) begin
        checks++; if (BUS_REQ !== 1'b1) begin errors++; $display("FAIL rnd_req_with_e c%0d: got %0b expected 1", c, BUS_REQ); end
        checks++; if (q.size() == 0 || I !== q[0]) begin
          errors++; $display("FAIL rnd_data c%0d: got %0h expected %0h (queued %0d)", c, I, (q.size() > 0) ? q[0] : 8'h00, q.size());
        end
        run++;
        xd = (run == HOLD);
        checks++; if (DONE !== xd) begin errors++; $display("FAIL rnd_done c%0d: got %0b expected %0b", c, DONE, xd); end
        if (xd) begin
          if (q.size() > 0) void'(q.pop_front());
          run = 0;
          burst++;
          completed++;
          checks++; if (burst > MAXB) begin errors++; $display("FAIL rnd_burst c%0d: got %0d bytes expected at most %0d", c, burst, MAXB); end
        end
      end else begin
        checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL rnd_done_idle c%0d: got %0b expected 0", c, DONE); end
        if (prev_e) begin
          since_fall = 0;
          if (prev_mid && aborts < 255) aborts++;
        end
        if (since_fall < TURN) begin
          checks++; if (BUS_REQ !== 1'b0) begin errors++; $display("FAIL rnd_turnaround c%0d: req=%0b expected 0", c, BUS_REQ); end
        end
        since_fall++;
        run = 0;
        burst = 0;
      end
`ifdef BUS_DRIVE_ABORT_CNT_EN
      checks++; if (ABORT_CNT !== 8'(aborts)) begin errors++; $display("FAIL rnd_abort_cnt c%0d: got %0d expected %0d", c, ABORT_CNT, aborts); end
`endif
      prev_mid = (E === 1'b1) && !xd;
      prev_e   = (E === 1'b1);
      prev_gnt = BUS_GNT;
      if (IN_VALID && rdy) q.push_back(IN_DATA);
      @(posedge CLK);
      #1;
    end
    checks++; if (q.size() != 0) begin errors++; $display("FAIL rnd_drain: %0d bytes left expected 0", q.size()); end
    checks++; if (completed < 50) begin errors++; $display("FAIL rnd_progress: %0d bytes completed expected at least 50", completed); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_burst_limit();
    test_grant_loss();
    test_full_fifo();
    test_reset_mid_drive();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
